// File: rtl/md_sequencer.sv
`default_nettype none
// md_sequencer: multi-cycle MULT/DIV controller for the E stage. The result is computed
// at issue, held pending for a fixed latency, then committed to HI/LO as Busy falls.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HI_write,
  input  logic        LO_write,
  input  logic        md_D,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        stall
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        skip_q, skip_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_bs, div_bu;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        b_zero, div_ovf;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands is the signed product.
    prod_s  = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u  = {32'd0, A} * {32'd0, B};
    b_zero  = (B == 32'd0);
    div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    // Dividing by 1 instead of -1 yields the required overflow result (0x80000000, 0)
    // and keeps the divider away from zero/overflow operands.
    div_bs  = (b_zero || div_ovf) ? 32'd1 : B;
    div_bu  = b_zero ? 32'd1 : B;
    quo_s   = $signed(A) / $signed(div_bs);
    rem_s   = $signed(A) % $signed(div_bs);
    quo_u   = A / div_bu;
    rem_u   = A % div_bu;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    skip_d    = skip_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (start) begin
          unique case (md_op)
            2'b00:   {pend_hi_d, pend_lo_d} = prod_s;
            2'b01:   {pend_hi_d, pend_lo_d} = prod_u;
            2'b10:   {pend_hi_d, pend_lo_d} = {rem_s, quo_s};
            default: {pend_hi_d, pend_lo_d} = {rem_u, quo_u};
          endcase
          cnt_d   = md_op[1] ? DIV_CNT : MULT_CNT;
          skip_d  = md_op[1] & b_zero;
          state_d = ST_RUN;
        end else begin
          if (HI_write) hi_d = A;
          if (LO_write) lo_d = A;
        end
      end
      default: begin
        // start / HI_write / LO_write are deliberately ignored while running.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (!skip_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      skip_q    <= skip_d;
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Busy  = (state_q == ST_RUN);
  assign stall = md_D & (start | Busy);

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// tb_md_sequencer: directed and randomized checks of md_sequencer against a
// transaction-level model (result computed at issue, committed at issue edge + N).
module tb_md_sequencer;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        HI_write = 1'b0;
  logic        LO_write = 1'b0;
  logic        md_D = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy, stall;

  md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .HI_write(HI_write), .LO_write(LO_write), .md_D(md_D),
    .HI(HI), .LO(LO), .Busy(Busy), .stall(stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: architectural HI/LO, pending result, and the edge index of the commit.
  logic [31:0] hi_m = 32'd0, lo_m = 32'd0, pend_hi_m = 32'd0, pend_lo_m = 32'd0;
  bit          skip_m = 1'b0;
  int          ecount = 0;
  int          run_end = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int          sa, sb;
    longint      na, nb, ma, mb, q, r;
    logic [63:0] ua, ub, res;
    sa = a;
    sb = b;
    na = sa;
    nb = sb;
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: res = na * nb;
      2'b01: res = ua * ub;
      2'b10: begin
        ma = (na < 0) ? -na : na;
        mb = (nb < 0) ? -nb : nb;
        q  = ma / mb;
        r  = ma % mb;
        if ((na < 0) != (nb < 0)) q = -q;
        if (na < 0) r = -r;
        res = {r[31:0], q[31:0]};
      end
      default: res = {a % b, a / b};
    endcase
    return res;
  endfunction

  // One clock cycle: drive inputs, check combinational stall, take the edge, check state.
  task automatic cycle(input logic st, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic hw, input logic lw, input logic md);
    logic [63:0] res;
    bit          busy_pre;
    start = st; md_op = op; A = a; B = b; HI_write = hw; LO_write = lw; md_D = md;
    busy_pre = (run_end > ecount);
    #2;
    check("stall", {63'd0, stall}, {63'd0, md & (st | busy_pre)});
    @(posedge clk);
    ecount++;
    if (!busy_pre) begin
      if (st) begin
        skip_m  = op[1] && (b == 32'd0);
        if (!skip_m) begin
          res = ref_result(op, a, b);
          pend_hi_m = res[63:32];
          pend_lo_m = res[31:0];
        end
        run_end = ecount + (op[1] ? DIV_N : MULT_N);
      end else begin
        if (hw) hi_m = a;
        if (lw) lo_m = a;
      end
    end else if (ecount == run_end && !skip_m) begin
      hi_m = pend_hi_m;
      lo_m = pend_lo_m;
    end
    #1;
    check("hi", {32'd0, HI}, {32'd0, hi_m});
    check("lo", {32'd0, LO}, {32'd0, lo_m});
    check("busy", {63'd0, Busy}, {63'd0, run_end > ecount});
  endtask

  // Idle-input cycles until Busy falls; returns the number of Busy cycles seen.
  task automatic drain(input logic md, output int nbusy);
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (!Busy) break;
      nbusy++;
      cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, md);
    end
  endtask

  task automatic op_and_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic md, output int nbusy);
    int n;
    cycle(1'b1, op, a, b, 1'b0, 1'b0, md);
    drain(md, n);
    nbusy = n;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    #1;
    check("rst_hi", {32'd0, HI}, 64'd0);
    check("rst_lo", {32'd0, LO}, 64'd0);
    check("rst_busy", {63'd0, Busy}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // MULT / MULTU of -2 and 3
    op_and_wait(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1, nb);
    check("mult_busy_len", 64'(nb), 64'(MULT_N));
    check("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    check("mult_lo", {32'd0, LO}, 64'hFFFF_FFFA);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    op_and_wait(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, nb);
    check("multu_hi", {32'd0, HI}, 64'h2);
    check("multu_lo", {32'd0, LO}, 64'hFFFF_FFFA);

    // DIV / DIVU
    op_and_wait(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, nb);
    check("div_busy_len", 64'(nb), 64'(DIV_N));
    check("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
    check("div_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    op_and_wait(2'b11, 32'd7, 32'd2, 1'b0, nb);
    check("divu_lo", {32'd0, LO}, 64'd3);
    check("divu_hi", {32'd0, HI}, 64'd1);

    // Divide by zero leaves preloaded HI/LO untouched
    cycle(1'b0, 2'b00, 32'h11, 32'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 32'h22, 32'd0, 1'b0, 1'b1, 1'b0);
    op_and_wait(2'b10, 32'd1234, 32'd0, 1'b1, nb);
    check("div0_busy_len", 64'(nb), 64'(DIV_N));
    check("div0_hi", {32'd0, HI}, 64'h11);
    check("div0_lo", {32'd0, LO}, 64'h22);

    // Signed overflow
    op_and_wait(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
    check("ovf_lo", {32'd0, LO}, 64'h8000_0000);
    check("ovf_hi", {32'd0, HI}, 64'h0);

    // Writes and starts during RUN are ignored
    cycle(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 32'h55, 32'd0, 1'b1, 1'b0, 1'b1);
    check("run_hw_ignored", {32'd0, HI}, 64'h0);
    cycle(1'b1, 2'b11, 32'h99, 32'd7, 1'b0, 1'b1, 1'b1);
    drain(1'b1, nb);
    check("run_ign_hi", {32'd0, HI}, 64'h0);
    check("run_ign_lo", {32'd0, LO}, 64'd12);

    // start wins over a same-cycle LO_write
    cycle(1'b1, 2'b01, 32'd2, 32'd3, 1'b0, 1'b1, 1'b0);
    check("start_drops_lw", {32'd0, LO}, 64'd12);
    drain(1'b0, nb);
    check("start_lw_lo", {32'd0, LO}, 64'd6);

    // Asynchronous reset mid-DIV
    cycle(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("arst_hi", {32'd0, HI}, 64'h0);
    check("arst_lo", {32'd0, LO}, 64'h0);
    check("arst_busy", {63'd0, Busy}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0; run_end = -1;
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("post_rst_stall_busy", {63'd0, Busy}, 64'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    check("post_rst_no_commit", {HI, LO}, 64'd0);

    // Randomized traffic, including illegal inputs while running
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), rand_word(), rand_word(),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle multiply/divide controller for the E stage of the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU issue from the E-stage controller and computes the result into a pending buffer.
- Holds Busy for a fixed latency, then commits the result to the architectural HI/LO registers.
- Drives the D-stage stall request that the hazard unit ORs into PC_en / IR_D_en / IR_E_clr. Also services the single-cycle MTHI/MTLO writes.

Parameters:
- MULT_CYCLES, 5, Busy cycles for MULT/MULTU (legal range 1–15).
- DIV_CYCLES, 10, Busy cycles for DIV/DIVU (legal range 1–15).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  E stage holds MULT/MULTU/DIV/DIVU this cycle
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; valid only when start=1
- A  in  32  forwarded rs value (MFRSE)
- B  in  32  forwarded rt value (MFRTE)
- HI_write  in  1  MTHI in E stage
- LO_write  in  1  MTLO in E stage
- md_D  in  1  D-stage instruction uses the MD unit (mult/div/mfhi/mflo/mthi/mtlo)
- HI  out  32  architectural HI
- LO  out  32  architectural LO
- Busy  out  1  operation in flight
- stall  out  1  stall request for the D stage

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, state=IDLE, cnt=0, pending regs=0. Reset asserted mid-operation aborts the operation; HI/LO stay 0 and no commit occurs.
- FSM states are IDLE and RUN; Busy = (state==RUN), registered.
- IDLE, start=1 at a posedge:
  - Latch pend_hi/pend_lo.
  - Load cnt = MULT_CYCLES for md_op[1]=0, otherwise DIV_CYCLES.
  - Go to RUN. Busy rises in the following cycle.
- RUN: cnt decrements each posedge. At the posedge where cnt==1: HI<=pend_hi, LO<=pend_lo, go to IDLE.
- Busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). The new HI/LO are visible the cycle Busy falls.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit A*B.
  - MULTU: unsigned 64-bit product.
  - DIV: lo = signed A/B, hi = signed A%B, truncating toward zero; remainder takes the sign of A.
  - DIVU: unsigned quotient and remainder.
- Divide by zero (B==0 on DIV/DIVU): the sequence runs for the full DIV_CYCLES, but HI/LO are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- HI_write/LO_write in IDLE with start=0: HI<=A (or LO<=A) at that posedge; 1-cycle effect with no Busy.
  - HI_write and LO_write are both legal in the same cycle.
- Simultaneous events and ignored inputs:
  - start together with HI_write/LO_write: start has priority and the write is dropped.
  - start, HI_write and LO_write received while in RUN are ignored. The hazard unit guarantees they do not occur; the bench checks that state is not corrupted if they do.
- stall = md_D & (start | Busy), combinational. No stall is raised for non-MD D-stage instructions while Busy.
- MFHI/MFLO read HI/LO directly. Because stall covers the whole window, no bypass of pend_* is needed.
- cnt is 4 bits and never wraps: it is loaded only in IDLE and held at 0 in IDLE.

Test Plan:
- Reset: reset=0 mid-RUN of a DIV → HI=LO=0, Busy=0 immediately (asynchronous); after release, md_D=1 gives stall=0.
- MULT A=0xFFFFFFFE (-2), B=3 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 → after 10 Busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1.
- Divide by zero: preload HI=0x11 via HI_write, LO=0x22 via LO_write; DIV with B=0 → Busy high 10 cycles, then HI=0x11, LO=0x22.
- Stall window: start MULT with md_D=1 → stall=1 in the start cycle and all 5 Busy cycles, and 0 the cycle Busy falls. With md_D=0 → stall stays 0 throughout.
- Ignored inputs: HI_write=1, A=0x55 during RUN → HI is unchanged until commit and ends equal to the product. start in the same cycle as LO_write → LO_write is dropped.
